inv_key_expansion: RTL and testbench
====================================

Name: inv_key_expansion

Overview:
Clocked AES-128 decryption key-schedule walker, the reverse-direction counterpart to the forward round-key generator. It takes the master key and runs the forward schedule once, one round per cycle, to reach and latch the round-10 key. It then steps backwards one round key per request (10 -> 0) with the inverse recurrence, so no 11-entry key store is needed. It sits between the key-load interface and the decryption round datapath, which pulls keys with key_req.

Parameters:
NR, 10, number of rounds; only 10 (AES-128) is supported, and elaboration fails on any other value.
LOAD_IS_FINAL, 0, 0 means key_in is the master key and the forward walk runs; 1 means key_in is already the round-10 key, the forward walk is skipped and READY is entered one cycle after load.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
key_in  in  128  key sampled on the key_load cycle; word 0 = [127:96].
key_load  in  1  single-cycle pulse: capture key_in and start a new schedule from any state.
key_req  in  1  pulse: step key_out to the previous round; honoured only in READY.
key_restart  in  1  pulse: rewind key_out to the latched round-10 key; honoured only in READY.
key_out  out  128  current round key (registered).
round_idx  out  4  round number of key_out, 0..10.
key_valid  out  1  high while in READY; key_out/round_idx are valid.
key_stepped  out  1  one-cycle pulse the cycle after an accepted key_req or key_restart.
busy  out  1  high in FWD.

Behaviour:
- Reset (async assert, sync release): state=IDLE; key_out=0, final_key=0, round_idx=0, key_valid=0, key_stepped=0, busy=0.
- Reset asserted mid-walk: the walk is abandoned and everything returns to reset values; no partial key survives.
- States: IDLE, FWD, READY.
- IDLE: outputs hold their reset values. key_load -> capture key_in into key_out and set round_idx=0.
  - LOAD_IS_FINAL=0: go to FWD.
  - LOAD_IS_FINAL=1: go to READY with round_idx=10 and final_key=key_in.
- FWD (busy=1, key_valid=0): each edge computes the next key from key_out and increments round_idx.
  - Forward step for round r = round_idx+1: n0 = w0^SubWord(RotWord(w3))^{RCON[r],24'h0}; n1 = w1^n0; n2 = w2^n1; n3 = w3^n2.
  - On the edge where round_idx becomes 10, also load final_key and go to READY.
  - Latency: key_load sampled at edge E0 -> key_valid=1 and round_idx=10 after edge E10.
- READY (key_valid=1):
  - key_req with round_idx>0 loads the inverse step into key_out, decrements round_idx and pulses key_stepped; latency is 1 cycle.
  - Inverse step for round i = round_idx: p3 = w3^w2; p2 = w2^w1; p1 = w1^w0; p0 = w0^SubWord(RotWord(p3))^{RCON[i],24'h0}.
  - key_req at round_idx=0 is ignored: no change and no key_stepped.
  - key_restart sets key_out=final_key and round_idx=10, pulses key_stepped, and is allowed at any round_idx including 10.
- Priority within a cycle: key_load > key_restart > key_req.
  - key_load in FWD or READY restarts from the new key_in, drops key_valid the next cycle and discards final_key.
- key_req or key_restart in IDLE or FWD: ignored with no queueing; the requester must wait for key_valid.
- RCON indexed 1..10: 01,02,04,08,10,20,40,80,1B,36. Index 0 is never used.
- One SubWord instance is shared between directions: its input mux selects w3 in FWD and p3 in READY.
- All XOR arithmetic is 32-bit; there is no carry and no width growth.

Decomposition:
- aes_pkg holds:
  - NR and KEY_W=128;
  - RCON as a function or constant array indexed 1..10;
  - the state enum {IDLE, FWD, READY};
  - helper functions rot_word() and the 128-bit word split.
- Sub-module aes_subword wraps four instances of the existing s_box for the 32-bit SubWord and is reusable by the round datapath.

Test Plan:
- Load master key 2b7e151628aed2a6abf7158809cf4f3c -> busy for 10 cycles, then key_valid=1, round_idx=10, key_out=d014f9a8c9ee2589e13f0cc8b6630ca6.
- From READY, one key_req -> after 1 cycle key_out=ac7766f319fadc2128d12941575c006e, round_idx=9, one key_stepped pulse.
  - Nine more key_req -> round 1 = a0fafe1788542cb123a339392a6c7605, round 0 = the master key.
  - An 11th key_req -> no change and no key_stepped.
- At round_idx=4, assert key_restart and key_req in the same cycle -> key_out=d014...0ca6, round_idx=10 (restart wins).
- During FWD (cycle 5), pulse key_load with key 000102030405060708090a0b0c0d0e0f -> walk restarts, and 10 cycles later key_out=13111d7fe3944a17f307a78b4d2b30c5.
- LOAD_IS_FINAL=1: load d014f9a8c9ee2589e13f0cc8b6630ca6 -> key_valid the next cycle with round_idx=10; 10 key_req then yield 2b7e1516...4f3c.
- Drop rst_n mid-FWD and mid-READY -> all outputs 0 immediately; key_req afterwards is ignored until a new key_load.

Source files
------------

// File: rtl/aes_pkg.sv
// AES key-schedule shared definitions.
//   NR, KEY_W  : round count and key width for AES-128
//   state_e    : key-schedule walker states
//   rcon()     : round constant, valid for indices 1..10
//   rot_word() : cyclic left byte rotation of a 32-bit word
//   key_word() : extract word i of a 128-bit key (word 0 = [127:96])
package aes_pkg;

    localparam int unsigned NR    = 10;
    localparam int unsigned KEY_W = 128;

    typedef enum logic [1:0] {IDLE, FWD, READY} state_e;

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] rc;
        case (idx)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] key_word(input logic [KEY_W-1:0] k, input int unsigned i);
        return k[KEY_W-1-32*i -: 32];
    endfunction

endpackage

// File: rtl/aes_subword.sv
// AES SubWord: S-box applied to each byte of a 32-bit word.
//   w   : input word
//   sub : byte-wise substituted word
module aes_subword (
    input  logic [31:0] w,
    output logic [31:0] sub
);

    for (genvar b = 0; b < 4; b++) begin : g_byte
        s_box u_s_box (
            .x (w[8*b +: 8]),
            .y (sub[8*b +: 8])
        );
    end

endmodule

// File: rtl/s_box.sv
// AES forward S-box, combinational.
//   x : input byte
//   y : substituted byte
// Computed as GF(2^8) inverse (x^254) followed by the AES affine transform.
module s_box (
    input  logic [7:0] x,
    output logic [7:0] y
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    function automatic logic [7:0] sub_byte(input logic [7:0] v);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = v;
        inv = 8'h01;
        // x^254 = x^2 * x^4 * ... * x^128; zero maps to zero
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    assign y = sub_byte(x);

endmodule

// File: rtl/inv_key_expansion.sv
// AES-128 decryption key-schedule walker. Walks the forward schedule to round 10 once,
// then steps backwards one round key per request using the inverse recurrence.
//   clk, rst_n   : clock, async active-low reset
//   key_in       : key captured on key_load (master key, or round-10 key if LOAD_IS_FINAL)
//   key_load     : start a new schedule from any state
//   key_req      : step to the previous round key (READY only, ignored at round 0)
//   key_restart  : rewind to the latched round-10 key (READY only)
//   key_out      : current round key
//   round_idx    : round number of key_out
//   key_valid    : in READY
//   key_stepped  : pulse the cycle after an accepted key_req/key_restart
//   busy         : forward walk in progress
module inv_key_expansion
    import aes_pkg::*;
#(
    parameter int unsigned NR            = 10,
    parameter bit          LOAD_IS_FINAL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_W-1:0] key_in,
    input  logic             key_load,
    input  logic             key_req,
    input  logic             key_restart,
    output logic [KEY_W-1:0] key_out,
    output logic [3:0]       round_idx,
    output logic             key_valid,
    output logic             key_stepped,
    output logic             busy
);

    if (NR != 10) begin : g_nr_check
        $error("inv_key_expansion supports only NR = 10 (AES-128)");
    end

    localparam logic [3:0] LastRound = 4'd10;

    state_e           state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [KEY_W-1:0] final_q, final_d;
    logic [3:0]       round_q, round_d;
    logic             stepped_q, stepped_d;

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] p1, p2, p3;
    logic [31:0] sub_in, sub_out;
    logic [31:0] n0, n1, n2, n3, p0;
    logic [KEY_W-1:0] fwd_key, inv_key;

    assign w0 = key_word(key_q, 0);
    assign w1 = key_word(key_q, 1);
    assign w2 = key_word(key_q, 2);
    assign w3 = key_word(key_q, 3);

    // Inverse recurrence recovers the previous w3 first, which then feeds SubWord
    assign p3 = w3 ^ w2;
    assign p2 = w2 ^ w1;
    assign p1 = w1 ^ w0;

    // Single SubWord shared by both directions
    assign sub_in = (state_q == FWD) ? rot_word(w3) : rot_word(p3);

    aes_subword u_subword (
        .w   (sub_in),
        .sub (sub_out)
    );

    assign n0 = w0 ^ sub_out ^ {rcon(round_q + 4'd1), 24'h0};
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign p0 = w0 ^ sub_out ^ {rcon(round_q), 24'h0};

    assign fwd_key = {n0, n1, n2, n3};
    assign inv_key = {p0, p1, p2, p3};

    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        final_d   = final_q;
        round_d   = round_q;
        stepped_d = 1'b0;
        if (key_load) begin
            key_d = key_in;
            if (LOAD_IS_FINAL) begin
                state_d = READY;
                round_d = LastRound;
                final_d = key_in;
            end else begin
                state_d = FWD;
                round_d = 4'd0;
                final_d = '0;
            end
        end else begin
            unique case (state_q)
                FWD: begin
                    key_d   = fwd_key;
                    round_d = round_q + 4'd1;
                    if (round_q == LastRound - 4'd1) begin
                        final_d = fwd_key;
                        state_d = READY;
                    end
                end
                READY: begin
                    if (key_restart) begin
                        key_d     = final_q;
                        round_d   = LastRound;
                        stepped_d = 1'b1;
                    end else if (key_req && (round_q != 4'd0)) begin
                        key_d     = inv_key;
                        round_d   = round_q - 4'd1;
                        stepped_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            key_q     <= '0;
            final_q   <= '0;
            round_q   <= 4'd0;
            stepped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            key_q     <= key_d;
            final_q   <= final_d;
            round_q   <= round_d;
            stepped_q <= stepped_d;
        end
    end

    assign key_out     = key_q;
    assign round_idx   = round_q;
    assign key_valid   = (state_q == READY);
    assign key_stepped = stepped_q;
    assign busy        = (state_q == FWD);

endmodule

// File: tb/tb_inv_key_expansion.sv
// Self-checking bench for inv_key_expansion: known-answer table, directed corner
// sequences, and randomized traffic checked against a round-key-table model.
module tb_inv_key_expansion;

    logic         clk;
    logic         rst_n;
    logic [127:0] key_in0, key_in1;
    logic         key_load0, key_req0, key_restart0;
    logic         key_load1, key_req1, key_restart1;
    logic [127:0] key_out0, key_out1;
    logic [3:0]   round_idx0, round_idx1;
    logic         key_valid0, key_valid1;
    logic         key_stepped0, key_stepped1;
    logic         busy0, busy1;

    inv_key_expansion #(.NR(10), .LOAD_IS_FINAL(1'b0)) dut0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_in      (key_in0),
        .key_load    (key_load0),
        .key_req     (key_req0),
        .key_restart (key_restart0),
        .key_out     (key_out0),
        .round_idx   (round_idx0),
        .key_valid   (key_valid0),
        .key_stepped (key_stepped0),
        .busy        (busy0)
    );

    inv_key_expansion #(.NR(10), .LOAD_IS_FINAL(1'b1)) dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_in      (key_in1),
        .key_load    (key_load1),
        .key_req     (key_req1),
        .key_restart (key_restart1),
        .key_out     (key_out1),
        .round_idx   (round_idx1),
        .key_valid   (key_valid1),
        .key_stepped (key_stepped1),
        .busy        (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [127:0] K_MASTER = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K_R10    = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K_R9     = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] K_R1     = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K_SEQ    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K_SEQ10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    // ---------------- reference model ----------------
    logic [7:0]   sbox [256];
    logic [127:0] m_rk [11];
    bit           m_loaded, m_busy, m_valid, m_stepped;
    int           m_idx;

    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] v);
        return {sbox[v[31:24]], sbox[v[23:16]], sbox[v[15:8]], sbox[v[7:0]]};
    endfunction

    // Classic generator walking p over GF(2^8)* with q = 1/p
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox[0] = 8'h63;
    endtask

    // Standard 44-word expansion
    task automatic expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic model_reset();
        m_loaded = 0; m_busy = 0; m_valid = 0; m_stepped = 0; m_idx = 0;
    endtask

    task automatic model_step(input bit ld, input logic [127:0] k, input bit rs, input bit rq);
        m_stepped = 0;
        if (ld) begin
            expand(k);
            m_loaded = 1; m_busy = 1; m_valid = 0; m_idx = 0;
        end else if (m_busy) begin
            m_idx++;
            if (m_idx == 10) begin m_busy = 0; m_valid = 1; end
        end else if (m_valid) begin
            if (rs) begin m_idx = 10; m_stepped = 1; end
            else if (rq && m_idx > 0) begin m_idx--; m_stepped = 1; end
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, " key_out"}, key_out0, m_loaded ? m_rk[m_idx] : 128'h0);
        chk({tag, " round_idx"}, 128'(round_idx0), 128'(m_idx));
        chk({tag, " key_valid"}, 128'(key_valid0), 128'(m_valid));
        chk({tag, " key_stepped"}, 128'(key_stepped0), 128'(m_stepped));
        chk({tag, " busy"}, 128'(busy0), 128'(m_busy));
    endtask

    task automatic step(input string tag);
        model_step(key_load0, key_in0, key_restart0, key_req0);
        @(posedge clk);
        #1;
        check_model(tag);
        key_load0 = 0; key_req0 = 0; key_restart0 = 0;
        key_load1 = 0; key_req1 = 0; key_restart1 = 0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " key_out0"}, key_out0, 128'h0);
        chk({tag, " status0"}, {123'h0, round_idx0, key_valid0, key_stepped0, busy0}, 128'h0);
        chk({tag, " key_out1"}, key_out1, 128'h0);
        chk({tag, " status1"}, {123'h0, round_idx1, key_valid1, key_stepped1, busy1}, 128'h0);
    endtask

    typedef struct {
        string        name;
        logic [127:0] key;
        int           idx;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_n;

        vecs[0] = '{"fips r10", K_MASTER, 10, K_R10};
        vecs[1] = '{"fips r9",  K_MASTER, 9,  K_R9};
        vecs[2] = '{"fips r1",  K_MASTER, 1,  K_R1};
        vecs[3] = '{"fips r0",  K_MASTER, 0,  K_MASTER};
        vecs[4] = '{"seq r10",  K_SEQ,    10, K_SEQ10};

        build_sbox();
        key_in0 = '0; key_load0 = 0; key_req0 = 0; key_restart0 = 0;
        key_in1 = '0; key_load1 = 0; key_req1 = 0; key_restart1 = 0;
        rst_n = 0;
        #1;
        check_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1;
        model_reset();

        // Known-answer table: load, walk forward, step back to the target round
        for (int v = 0; v < 5; v++) begin
            key_load0 = 1; key_in0 = vecs[v].key;
            step({vecs[v].name, " load"});
            busy_n = 0;
            for (int c = 0; c < 20 && key_valid0 !== 1'b1; c++) begin
                if (busy0) busy_n++;
                step({vecs[v].name, " fwd"});
            end
            chk({vecs[v].name, " busy cycles"}, 128'(busy_n), 128'd10);
            for (int s = 0; s < 10 - vecs[v].idx; s++) begin
                key_req0 = 1;
                step({vecs[v].name, " req"});
            end
            chk({vecs[v].name, " key"}, key_out0, vecs[v].exp);
            chk({vecs[v].name, " round"}, 128'(round_idx0), 128'(vecs[v].idx));
            chk({vecs[v].name, " stepped"}, 128'(key_stepped0), 128'(vecs[v].idx < 10));
            if (vecs[v].idx == 0) begin
                key_req0 = 1;
                step("extra req");
                chk("extra req key", key_out0, K_MASTER);
                chk("extra req round", 128'(round_idx0), 128'd0);
                chk("extra req stepped", 128'(key_stepped0), 128'd0);
            end
        end

        // Restart wins over req at round 4
        key_load0 = 1; key_in0 = K_MASTER;
        step("rs load");
        for (int c = 0; c < 10; c++) step("rs fwd");
        for (int c = 0; c < 6; c++) begin key_req0 = 1; step("rs req"); end
        chk("rs at4 round", 128'(round_idx0), 128'd4);
        key_restart0 = 1; key_req0 = 1;
        step("rs both");
        chk("restart key", key_out0, K_R10);
        chk("restart round", 128'(round_idx0), 128'd10);
        chk("restart stepped", 128'(key_stepped0), 128'd1);
        key_restart0 = 1;
        step("rs at 10");
        chk("restart at 10 stepped", 128'(key_stepped0), 128'd1);

        // Reload during the forward walk
        key_load0 = 1; key_in0 = K_MASTER;
        step("reload load");
        for (int c = 0; c < 5; c++) step("reload fwd");
        key_load0 = 1; key_in0 = K_SEQ;
        step("reload new");
        for (int c = 0; c < 10; c++) step("reload fwd2");
        chk("reload key", key_out0, K_SEQ10);
        chk("reload valid", 128'(key_valid0), 128'd1);

        // LOAD_IS_FINAL instance
        key_load1 = 1; key_in1 = K_R10;
        step("final load");
        chk("final valid", 128'(key_valid1), 128'd1);
        chk("final round", 128'(round_idx1), 128'd10);
        chk("final key", key_out1, K_R10);
        chk("final busy", 128'(busy1), 128'd0);
        for (int s = 0; s < 10; s++) begin key_req1 = 1; step("final req"); end
        chk("final walk key", key_out1, K_MASTER);
        chk("final walk round", 128'(round_idx1), 128'd0);

        // Reset mid-FWD
        key_load0 = 1; key_in0 = K_MASTER;
        step("rst fwd load");
        for (int c = 0; c < 3; c++) step("rst fwd");
        #2 rst_n = 0;
        #1 check_zero("reset mid fwd");
        #2 rst_n = 1;
        model_reset();
        key_req0 = 1; key_restart0 = 1;
        step("req after reset");
        chk("req after reset key", key_out0, 128'h0);

        // Reset mid-READY
        key_load0 = 1; key_in0 = K_SEQ;
        step("rst rdy load");
        for (int c = 0; c < 10; c++) step("rst rdy fwd");
        for (int c = 0; c < 2; c++) begin key_req0 = 1; step("rst rdy req"); end
        key_load1 = 1; key_in1 = K_R10;
        step("rst rdy final");
        #2 rst_n = 0;
        #1 check_zero("reset mid ready");
        #2 rst_n = 1;
        model_reset();
        key_req0 = 1;
        step("req after reset2");
        chk("req after reset2 valid", 128'(key_valid0), 128'd0);

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            key_load0    = ($urandom_range(0, 30) == 0);
            key_in0      = {$urandom, $urandom, $urandom, $urandom};
            key_restart0 = ($urandom_range(0, 15) == 0);
            key_req0     = $urandom_range(0, 1) == 1;
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
